// File: rtl/multiplier_core.sv
// Unsigned SIZE x SIZE array multiplier: AND-gate partial products summed by
// ripple-carry adder rows, with a registered product and overflow flag.
module multiplier_core #(
  parameter int unsigned SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              over,
  output logic [2*SIZE-1:0] c
);

  localparam int unsigned PW = 2 * SIZE;

  logic [SIZE-1:0] pp_c [SIZE];
  logic [PW-1:0]   prod_c;
  logic            over_c;

  logic [PW-1:0]   c_q, c_d;
  logic            over_q, over_d;

  // One-bit full adder; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // Partial products: row i is a gated by b[i].
  always_comb begin
    for (int i = 0; i < int'(SIZE); i++) begin
      for (int j = 0; j < int'(SIZE); j++) begin
        pp_c[i][j] = a[j] & b[i];
      end
    end
  end

  // Accumulator holds the running row sum (SIZE bits) plus its carry-out on
  // top; each row retires its LSB into the product and shifts right by one.
  always_comb begin
    logic [SIZE:0]   acc;
    logic [SIZE-1:0] row_sum;
    logic [1:0]      fa;
    logic            cy;
    prod_c  = '0;
    row_sum = '0;
    fa      = '0;
    cy      = 1'b0;
    acc     = {1'b0, pp_c[0]};
    prod_c[0] = acc[0];
    for (int i = 1; i < int'(SIZE); i++) begin
      cy = 1'b0;
      for (int j = 0; j < int'(SIZE); j++) begin
        fa         = full_add(acc[j+1], pp_c[i][j], cy);
        row_sum[j] = fa[0];
        cy         = fa[1];
      end
      acc       = {cy, row_sum};
      prod_c[i] = acc[0];
    end
    // Final row supplies bits SIZE-1 .. 2*SIZE-1, its carry being the MSB.
    prod_c[PW-1:SIZE-1] = acc;
  end

  assign over_c = |prod_c[PW-1:SIZE];

  always_comb begin
    c_d    = prod_c;
    over_d = over_c;
  end

  // Output stage; synchronous reset takes priority over a new product.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q    <= '0;
      over_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      over_q <= over_d;
    end
  end

  assign c    = c_q;
  assign over = over_q;

endmodule

// File: tb/tb_multiplier_core.sv
// Directed and swept checks of multiplier_core at SIZE=2 and SIZE=8,
// including reset behaviour and boundary operands.
module tb_multiplier_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  a2, b2;
  logic [3:0]  c2;
  logic        over2;
  logic [7:0]  a8, b8;
  logic [15:0] c8;
  logic        over8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multiplier_core #(.SIZE(2)) u_dut2 (
    .clk  (clk),
    .rst  (rst),
    .a    (a2),
    .b    (b2),
    .over (over2),
    .c    (c2)
  );

  multiplier_core #(.SIZE(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .a    (a8),
    .b    (b8),
    .over (over8),
    .c    (c8)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] c;
    logic       ov;
  } vec2_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
    logic        ov;
  } vec8_t;

  vec2_t v2 [6];
  vec8_t v8 [7];

  initial begin
    v2[0] = '{2'b11, 2'b00, 4'b0000, 1'b0};
    v2[1] = '{2'b11, 2'b01, 4'b0011, 1'b0};
    v2[2] = '{2'b11, 2'b10, 4'b0110, 1'b1};
    v2[3] = '{2'b11, 2'b11, 4'b1001, 1'b1};
    v2[4] = '{2'b01, 2'b10, 4'b0010, 1'b0};
    v2[5] = '{2'b10, 2'b10, 4'b0100, 1'b1};

    v8[0] = '{8'hFF, 8'hFF, 16'hFE01, 1'b1};
    v8[1] = '{8'h0F, 8'h11, 16'h00FF, 1'b0};
    v8[2] = '{8'h01, 8'hA5, 16'h00A5, 1'b0};
    v8[3] = '{8'hC3, 8'h01, 16'h00C3, 1'b0};
    v8[4] = '{8'h00, 8'hFF, 16'h0000, 1'b0};
    v8[5] = '{8'h10, 8'h10, 16'h0100, 1'b1};
    v8[6] = '{8'h80, 8'h02, 16'h0100, 1'b1};

    // Reset held two cycles with non-zero operands.
    rst = 1'b1;
    a2  = 2'b11;
    b2  = 2'b11;
    a8  = 8'hFF;
    b8  = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_c2", 16'(c2), 16'h0000);
      check("rst_ov2", 16'(over2), 16'h0000);
      check("rst_c8", c8, 16'h0000);
      check("rst_ov8", 16'(over8), 16'h0000);
    end
    rst = 1'b0;

    // Back-to-back directed operands; each result one edge after its operands.
    for (int k = 0; k < 6; k++) begin
      a2 = v2[k].a;
      b2 = v2[k].b;
      a8 = v8[k].a;
      b8 = v8[k].b;
      step();
      check($sformatf("dir2_c_%0d", k), 16'(c2), 16'(v2[k].c));
      check($sformatf("dir2_ov_%0d", k), 16'(over2), 16'(v2[k].ov));
      check($sformatf("dir8_c_%0d", k), c8, v8[k].c);
      check($sformatf("dir8_ov_%0d", k), 16'(over8), 16'(v8[k].ov));
    end
    a8 = v8[6].a;
    b8 = v8[6].b;
    step();
    check("dir8_c_6", c8, v8[6].c);
    check("dir8_ov_6", 16'(over8), 16'(v8[6].ov));

    // Exhaustive SIZE=2 against a*b reference.
    for (int k = 0; k < 16; k++) begin
      logic [3:0] ka;
      logic [3:0] exp2;
      ka   = 4'(k);
      a2   = ka[3:2];
      b2   = ka[1:0];
      exp2 = 4'(a2) * 4'(b2);
      step();
      check($sformatf("ex2_c_%0d", k), 16'(c2), 16'(exp2));
      check($sformatf("ex2_ov_%0d", k), 16'(over2), 16'(exp2[3:2] != 2'b00));
    end

    // Random SIZE=8 sweep with reset asserted mid-stream.
    for (int k = 0; k < 40; k++) begin
      logic [15:0] exp8;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (k == 20) begin
        rst = 1'b1;
        step();
        check("mid_rst_c8", c8, 16'h0000);
        check("mid_rst_ov8", 16'(over8), 16'h0000);
        check("mid_rst_c2", 16'(c2), 16'h0000);
        rst = 1'b0;
      end
      exp8 = 16'(a8) * 16'(b8);
      step();
      check($sformatf("rnd8_c_%0d", k), c8, exp8);
      check($sformatf("rnd8_ov_%0d", k), 16'(over8), 16'(exp8[15:8] != 8'h00));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
